dcache_ctrl: RTL
================

Name: dcache_ctrl

Overview:
- Direct-mapped, write-through, no-write-allocate data cache between the datapath's load/store port and the byte-lane data memory.
- Lookup is by word address. Read hits return data in the same cycle with no stall.
- Read misses and all writes run a fixed-latency memory transaction while `stall` is held high; `stall` gates the PC write enable.

Parameters:
- XLEN, 32, data/address width.
- LINES, 8, number of one-word lines; power of two, at least 2.
- MEM_LATENCY, 3, cycles a memory access occupies; at least 1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_b  in  1  synchronous, active-low reset.
- cpu_addr  in  XLEN  byte address; bits [1:0] ignored.
- cpu_read  in  1  load request.
- cpu_write  in  1  store request; wins if asserted together with cpu_read.
- cpu_wdata  in  8 x [0:3]  store data, byte lanes, lane 0 = bits 7:0.
- cpu_rdata  out  8 x [0:3]  load data, byte lanes.
- stall  out  1  hold PC and pipeline (datapath pc_we = !stall).
- mem_addr  out  XLEN  memory address, word-aligned.
- mem_we  out  1  memory write strobe.
- mem_data_in  out  8 x [0:3]  memory write data.
- mem_data_out  in  8 x [0:3]  memory read data.
- perf_misses  out  XLEN  saturating read-miss count.

Behaviour:
- Address split: index = addr[2+IB-1:2], where IB = log2(LINES); tag = addr[XLEN-1:2+IB].
- Reset (rst_b=0 at an edge):
  - state goes to IDLE, cnt=0, all valid bits cleared, perf_misses=0.
  - Data and tag arrays are not reset.
  - Reset applied mid-transaction abandons it; no mem_we is issued in that cycle or afterwards.
- Outputs while in reset or idle with no request: stall=0, mem_we=0, mem_addr=0, mem_data_in=0, cpu_rdata=0.
- IDLE, read, hit (valid and tag match): cpu_rdata = line data combinationally, stall=0, state stays IDLE.
- IDLE, read, miss:
  - stall=1; go to RD.
  - cnt=0; latch the word address; perf_misses += 1, saturating at all-ones.
- IDLE, write (hit or miss): stall=1; go to WR; cnt=0; latch the address and wdata.
- RD state:
  - mem_addr = latched address; stall=1; cnt increments each cycle.
  - When cnt == MEM_LATENCY-1: sample mem_data_out into the line, set valid, write the tag, then go to IDLE.
  - The next cycle re-looks-up and hits, so stall drops there.
  - Read-miss penalty = MEM_LATENCY+1 stall cycles.
- WR state:
  - mem_addr and mem_data_in held from latches.
  - For cnt < MEM_LATENCY-1: stall=1.
  - When cnt == MEM_LATENCY-1: mem_we=1 for exactly this cycle and stall=0, so the CPU retires the store at this edge. If the latched address hits, the line data is updated at the same edge (valid and tag unchanged). Go to IDLE.
  - A write miss never allocates a line.
  - Store penalty = MEM_LATENCY stall cycles.
- cpu_read and cpu_write both high: treated as a write only; no read lookup and no miss count.
- Request inputs are ignored outside IDLE; the CPU holds them stable while stall=1.
- Back-to-back accesses:
  - A request present in the cycle after WR completes is a new access.
  - A read of the just-written address hits with the new data, or misses (no-allocate) and fetches the already-committed data.
- Two addresses with the same index and different tags evict each other; no dirty state exists.
- Memory model contract: the memory combinationally reflects mem_addr and commits a write on the edge where mem_we=1.

Decomposition:
- Package dcache_pkg holds:
  - state enum {IDLE, RD, WR};
  - index/tag width constants derived from XLEN and LINES;
  - functions get_index(addr) and get_tag(addr);
  - helpers packing byte lanes to/from a word.
- Sub-module dcache_line_array (name fixed) holds:
  - LINES x {valid, tag, data} storage;
  - one combinational read port;
  - one synchronous write port with fill and update modes;
  - a synchronous active-low clear of the valid bits.
- The FSM, counter and perf counter stay in dcache_ctrl.

Test Plan:
1. Reset, then load 0x40 with memory holding 0xDEADBEEF: stall high 4 cycles; next cycle cpu_rdata=0xDEADBEEF, stall=0; perf_misses=1.
2. Repeat load 0x40: zero stall cycles, data 0xDEADBEEF the same cycle; perf_misses stays 1.
3. Store 0x12345678 to 0x40 (hit): stall high 3 cycles; mem_we is a single pulse in the 3rd WR cycle (cnt=2) with mem_addr=0x40; a following load of 0x40 returns 0x12345678 with no stall.
4. Store to 0x80 (miss, same index as 0x40 when LINES=8... use 0x60): memory updated; following load of 0x60 misses, costs 4 stall cycles, returns the stored value.
5. Loads to 0x40 then 0x60 (same index 0, different tags), alternating: every access misses; perf_misses increments by 1 each time.
6. Assert rst_b=0 during the 2nd RD cycle: at the next edge stall=0 and mem_we=0; a load of 0x40 misses again (valid bits cleared); cpu_read and cpu_write both high performs a store only.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared types, geometry constants and lane-packing helpers for the direct-mapped data cache.
package dcache_pkg;

  localparam int unsigned DefXlen  = 32;
  localparam int unsigned DefLines = 8;
  localparam int unsigned IdxW     = $clog2(DefLines);
  localparam int unsigned TagW     = DefXlen - 2 - IdxW;

  typedef logic [1:0] state_t;
  localparam state_t StIdle = 2'd0;
  localparam state_t StRd   = 2'd1;
  localparam state_t StWr   = 2'd2;

  typedef logic [7:0] lanes_t [0:3];

  function automatic logic [IdxW-1:0] get_index(input logic [DefXlen-1:0] addr);
    return addr[2+IdxW-1:2];
  endfunction

  function automatic logic [TagW-1:0] get_tag(input logic [DefXlen-1:0] addr);
    return addr[DefXlen-1:2+IdxW];
  endfunction

  function automatic logic [31:0] pack_lanes(input lanes_t lanes);
    return {lanes[3], lanes[2], lanes[1], lanes[0]};
  endfunction

  function automatic logic [7:0] get_lane(input logic [31:0] word, input int unsigned lane);
    return word[8*lane +: 8];
  endfunction

endpackage

// File: rtl/dcache_line_array.sv
// Valid/tag/data storage: one combinational read port, one synchronous fill/update write port.
module dcache_line_array #(
  parameter int unsigned LINES = 8,
  parameter int unsigned IDX_W = 3,
  parameter int unsigned TAG_W = 27
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic [IDX_W-1:0] rd_index,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output logic [31:0]      rd_data,
  input  logic             wr_en,
  input  logic             wr_fill,
  input  logic [IDX_W-1:0] wr_index,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [31:0]      wr_data
);

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [31:0]      data_q [LINES];

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_data  = data_q[rd_index];

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      valid_q <= '0;
    end else if (wr_en && wr_fill) begin
      valid_q[wr_index] <= 1'b1;
    end
  end

  // Tag and data are deliberately left unreset; valid alone qualifies them.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      data_q[wr_index] <= wr_data;
      if (wr_fill) begin
        tag_q[wr_index] <= wr_tag;
      end
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-through, no-write-allocate data cache controller with fixed-latency memory.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int unsigned XLEN        = DefXlen,
  parameter int unsigned LINES       = DefLines,
  parameter int unsigned MEM_LATENCY = 3
) (
  input  logic            clk,
  input  logic            rst_b,
  input  logic [XLEN-1:0] cpu_addr,
  input  logic            cpu_read,
  input  logic            cpu_write,
  input  logic [7:0]      cpu_wdata    [0:3],
  output logic [7:0]      cpu_rdata    [0:3],
  output logic            stall,
  output logic [XLEN-1:0] mem_addr,
  output logic            mem_we,
  output logic [7:0]      mem_data_in  [0:3],
  input  logic [7:0]      mem_data_out [0:3],
  output logic [XLEN-1:0] perf_misses
);

  localparam int unsigned IB = $clog2(LINES);
  localparam int unsigned TW = XLEN - 2 - IB;
  localparam int unsigned CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CW-1:0] CntLast = CW'(MEM_LATENCY - 1);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] perf_q, perf_d;
  logic [XLEN-3:0] word_q, word_d;
  logic [31:0]     wdata_q, wdata_d;

  logic [XLEN-3:0] lk_word;
  logic            rd_valid, hit, last, arr_we, arr_fill;
  logic [TW-1:0]   rd_tag;
  logic [31:0]     rd_data, rdata_w, mem_wdata_w;
  logic            unused_addr_bits;

  assign unused_addr_bits = ^cpu_addr[1:0];

  // In IDLE the incoming request is looked up; otherwise the latched address drives fill/update.
  assign lk_word = (state_q == StIdle) ? cpu_addr[XLEN-1:2] : word_q;
  assign hit     = rd_valid && (rd_tag == lk_word[XLEN-3:IB]);
  assign last    = (cnt_q == CntLast);

  dcache_line_array #(
    .LINES(LINES),
    .IDX_W(IB),
    .TAG_W(TW)
  ) u_lines (
    .clk     (clk),
    .rst_b   (rst_b),
    .rd_index(lk_word[IB-1:0]),
    .rd_valid(rd_valid),
    .rd_tag  (rd_tag),
    .rd_data (rd_data),
    .wr_en   (arr_we),
    .wr_fill (arr_fill),
    .wr_index(lk_word[IB-1:0]),
    .wr_tag  (lk_word[XLEN-3:IB]),
    .wr_data (arr_fill ? pack_lanes(mem_data_out) : wdata_q)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    perf_d      = perf_q;
    word_d      = word_q;
    wdata_d     = wdata_q;
    stall       = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata_w = '0;
    rdata_w     = '0;
    arr_we      = 1'b0;
    arr_fill    = 1'b0;
    // Everything is gated while reset is asserted so an abandoned write never strobes.
    if (rst_b) begin
      case (state_q)
        StIdle: begin
          if (cpu_write) begin
            stall   = 1'b1;
            state_d = StWr;
            cnt_d   = '0;
            word_d  = cpu_addr[XLEN-1:2];
            wdata_d = pack_lanes(cpu_wdata);
          end else if (cpu_read) begin
            if (hit) begin
              rdata_w = rd_data;
            end else begin
              stall   = 1'b1;
              state_d = StRd;
              cnt_d   = '0;
              word_d  = cpu_addr[XLEN-1:2];
              if (perf_q != '1) perf_d = perf_q + XLEN'(1);
            end
          end
        end
        StRd: begin
          mem_addr = {word_q, 2'b00};
          stall    = 1'b1;
          cnt_d    = cnt_q + CW'(1);
          if (last) begin
            arr_we   = 1'b1;
            arr_fill = 1'b1;
            state_d  = StIdle;
            cnt_d    = '0;
          end
        end
        StWr: begin
          mem_addr    = {word_q, 2'b00};
          mem_wdata_w = wdata_q;
          stall       = !last;
          cnt_d       = cnt_q + CW'(1);
          if (last) begin
            mem_we  = 1'b1;
            arr_we  = hit;
            state_d = StIdle;
            cnt_d   = '0;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      cpu_rdata[i]   = get_lane(rdata_w, i);
      mem_data_in[i] = get_lane(mem_wdata_w, i);
    end
  end

  assign perf_misses = perf_q;

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      perf_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      perf_q  <= perf_d;
    end
  end

  always_ff @(posedge clk) begin
    word_q  <= word_d;
    wdata_q <= wdata_d;
  end

endmodule
